// File: rtl/load_store_unit.sv
// Memory-access stage: turns byte/half/word loads and stores into word accesses
// on the segmented data memory, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int WIDTH    = 32,
  parameter int RAMSIZE  = 128,
  parameter int SEGMENTS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_error,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam int WORDS = SEGMENTS * RAMSIZE;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MERGE, S_WRITE, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [WIDTH-1:0] addr_q, wd_q, rdata_q;
  logic             err_q;

  logic             accept, misalign, oor, req_err;
  logic [1:0]       lane;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [WIDTH-1:0] load_ext, merged;

  assign accept   = req_valid && (state_q == S_IDLE);
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  // Compare the full word index so high addresses never alias into range.
  assign oor      = (req_addr >> 2) >= WIDTH'(WORDS);
  assign req_err  = misalign || oor || (req_size == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (req_err)               state_d = S_RESP;
        else if (!req_write)       state_d = S_LOAD;
        else if (req_size == 2'b10) state_d = S_WRITE;
        else                       state_d = S_MERGE;
      end
      S_LOAD:  state_d = S_RESP;
      S_MERGE: state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Little-endian lane extraction and merge on the addressed word.
  assign lane   = addr_q[1:0];
  assign byte_v = mem_rd[{lane, 3'b000} +: 8];
  assign half_v = mem_rd[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_rd;
    case (size_q)
      2'b00:   load_ext = {{(WIDTH-8){signed_q & byte_v[7]}}, byte_v};
      2'b01:   load_ext = {{(WIDTH-16){signed_q & half_v[15]}}, half_v};
      default: load_ext = mem_rd;
    endcase
  end

  always_comb begin
    merged = mem_rd;
    if (size_q == 2'b00) merged[{lane, 3'b000} +: 8]     = wd_q[7:0];
    else                 merged[{lane[1], 4'b0000} +: 16] = wd_q[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wd_q     <= req_wdata;
        rdata_q  <= '0;
        err_q    <= req_err;
      end
      if (state_q == S_LOAD)  rdata_q <= load_ext;
      if (state_q == S_MERGE) wd_q    <= merged;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q >> 2;
  assign mem_wd     = wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-array memory model.
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [0:767];
  int tests = 0, fails = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_addr < 32'd768) ? mem[mem_addr[9:0]] : 32'h0;
  always @(posedge clk) if (mem_we && mem_addr < 32'd768) mem[mem_addr[9:0]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: returns response data/error, accept-to-resp latency and write info.
  logic [31:0] r_data, w_addr, w_data;
  logic        r_err;
  int          r_lat, w_cnt;

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat = 99; w_cnt = 0; r_data = 'x; r_err = 1'bx; w_addr = 'x; w_data = 'x;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (mem_we) begin w_cnt++; w_addr = mem_addr; w_data = mem_wd; end
      if (resp_valid) begin r_lat = n; r_data = resp_rdata; r_err = resp_error; break; end
    end
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 768; i++) mem[i] = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_rerr", 32'(resp_error), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_mwd", mem_wd, 32'h0);
    rst = 1'b0;

    // word store / load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_lat", r_lat, 2); check("sw_wecnt", w_cnt, 1);
    check("sw_addr", w_addr, 32'd4); check("sw_wd", w_data, 32'hDEADBEEF);
    check("sw_err", 32'(r_err), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_lat", r_lat, 2); check("lw_data", r_data, 32'hDEADBEEF);
    check("lw_err", 32'(r_err), 32'd0); check("lw_wecnt", w_cnt, 0);

    // byte store with read-modify-write, then byte loads
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
    check("sb_lat", r_lat, 3); check("sb_wecnt", w_cnt, 1);
    check("sb_wd", w_data, 32'hA5ADBEEF); check("sb_mem", mem[4], 32'hA5ADBEEF);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lb_s", r_data, 32'hFFFFFFA5);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb_u", r_data, 32'h000000A5);
    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    check("lb_s_lane0", r_data, 32'hFFFFFFEF);

    // half store over lanes 2/3
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1357);
    check("sh_lat", r_lat, 3); check("sh_wd", w_data, 32'h1357BEEF);

    // half loads, misaligned half
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h80011234);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    check("lh_s_hi", r_data, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    check("lh_s_lo", r_data, 32'h00001234);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    check("lh_u_hi", r_data, 32'h00008001);
    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
    check("mis_err", 32'(r_err), 32'd1); check("mis_data", r_data, 32'h0);
    check("mis_lat", r_lat, 1); check("mis_we", w_cnt, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h11111111);
    check("mis_sw_err", 32'(r_err), 32'd1); check("mis_sw_we", w_cnt, 0);

    // range limits
    do_req(1'b1, 2'b10, 1'b0, 32'hBFC, 32'hCAFEF00D);
    check("top_err", 32'(r_err), 32'd0); check("top_addr", w_addr, 32'd767);
    check("top_mem", mem[767], 32'hCAFEF00D);
    do_req(1'b1, 2'b10, 1'b0, 32'hC00, 32'h12345678);
    check("oor_err", 32'(r_err), 32'd1); check("oor_we", w_cnt, 0); check("oor_lat", r_lat, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0);
    check("wrap_err", 32'(r_err), 32'd1); check("wrap_data", r_data, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h0);
    check("size11_err", 32'(r_err), 32'd1); check("size11_we", w_cnt, 0);
    check("size11_mem", mem[4], 32'h1357BEEF);

    // req_valid held across two requests
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_write = 1'b0;
    @(negedge clk); check("hold_c1_ready", 32'(req_ready), 32'd0);
    @(negedge clk); check("hold_c2_ready", 32'(req_ready), 32'd0);
    check("hold_c2_rvalid", 32'(resp_valid), 32'd1);
    @(negedge clk); check("hold_c3_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); check("hold_c4_ready", 32'(req_ready), 32'd0);
    @(negedge clk); check("hold_c5_rvalid", 32'(resp_valid), 32'd1);
    check("hold_c5_data", resp_rdata, 32'h12345678);

    // reset during MERGE of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h31; req_wdata = 32'h77;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); check("mrg_ready", 32'(req_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_rvalid", 32'(resp_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (resp_valid || mem_we) seen++; end
    check("arst_quiet", seen, 0);
    check("arst_mem", mem[12], 32'h12345678);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("arst_reload", r_data, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
